locked_regfile: RTL and testbench

- Parametrised register file with per-register write-reservation counters (locks).
- Sits between decode and execute: decode issues a read of two sources plus an optional destination reservation; writeback releases the reservation.
- Issue is accepted only when both sources are hazard-free, which replaces ad-hoc read/write gating in the pipeline.
- Reads return on a registered valid/ready output with 1-cycle latency; optional writeback-to-read bypass.

---
 rtl/locked_regfile.sv | 123 ++++++++++++
 tb/tb_locked_regfile.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/locked_regfile.sv
// Register file with per-register write-reservation counters.
// An issue reads two sources with one cycle of latency, and it may reserve a destination for a later writeback.
module locked_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    input  logic              iss_rsv,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              locked_any
);

    localparam int unsigned      NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] MAXR     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_rs1_data_q, out_rs1_data_d;
    logic [DATA_W-1:0] out_rs2_data_q, out_rs2_data_d;
    logic              locked_any_q, locked_any_d;

    logic [CNT_W-1:0]  cnt_rs1, cnt_rs2, cnt_rd;
    logic              src1_ok, src2_ok, rel_rd, rsv_eff, dst_ok, out_free, accept;
    logic              wb_keep;

    // Issue handshake: depends on the lock state and writeback, never on iss_valid.
    always_comb begin
        cnt_rs1   = cnt_q[iss_rs1];
        cnt_rs2   = cnt_q[iss_rs2];
        cnt_rd    = cnt_q[iss_rd];
        src1_ok   = (cnt_rs1 == '0) ||
                    (BYPASS && wb_en && (wb_addr == iss_rs1) && (cnt_rs1 == CNT_ONE));
        src2_ok   = (cnt_rs2 == '0) ||
                    (BYPASS && wb_en && (wb_addr == iss_rs2) && (cnt_rs2 == CNT_ONE));
        rel_rd    = wb_en && (wb_addr == iss_rd) && (cnt_rd != '0);
        rsv_eff   = iss_rsv && !(ZERO_REG && (iss_rd == '0));
        dst_ok    = !rsv_eff || (cnt_rd != MAXR) || rel_rd;
        out_free  = !out_valid_q || out_ready;
        iss_ready = out_free && src1_ok && src2_ok && dst_ok;
        accept    = iss_valid && iss_ready;
        wb_keep   = wb_en && !(ZERO_REG && (wb_addr == '0));
    end

    // Next state for the output slot, the register contents and the reservation counters.
    always_comb begin
        regs_d         = regs_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        locked_any_d   = 1'b0;

        if (accept) begin
            out_valid_d = 1'b1;
            if (ZERO_REG && (iss_rs1 == '0))             out_rs1_data_d = '0;
            else if (wb_en && (wb_addr == iss_rs1))      out_rs1_data_d = wb_data;
            else                                         out_rs1_data_d = regs_q[iss_rs1];
            if (ZERO_REG && (iss_rs2 == '0))             out_rs2_data_d = '0;
            else if (wb_en && (wb_addr == iss_rs2))      out_rs2_data_d = wb_data;
            else                                         out_rs2_data_d = regs_q[iss_rs2];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (wb_keep) begin
            regs_d[wb_addr] = wb_data;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            logic inc, dec;
            inc = accept && rsv_eff && (iss_rd == ADDR_W'(i));
            dec = wb_en && (wb_addr == ADDR_W'(i)) && (cnt_q[i] != '0);
            if (inc && !dec)      cnt_d[i] = cnt_q[i] + CNT_ONE;
            else if (dec && !inc) cnt_d[i] = cnt_q[i] - CNT_ONE;
            if (cnt_d[i] != '0)   locked_any_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            out_valid_q    <= 1'b0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            locked_any_q   <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            locked_any_q   <= locked_any_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = out_rs1_data_q;
    assign out_rs2_data = out_rs2_data_q;
    assign locked_any   = locked_any_q;

endmodule

// File: tb/tb_locked_regfile.sv
// Directed test of locked_regfile. The main instance has the bypass enabled.
// A second instance without the bypass gets the same stimulus, so the two issue timings can be compared.
module tb_locked_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid, iss_rsv, out_ready, wb_en;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_addr;
    logic [31:0] wb_data;
    logic        iss_ready, out_valid, locked_any;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic        nb_iss_ready, nb_out_valid, nb_locked_any;
    logic [31:0] nb_out_rs1_data, nb_out_rs2_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    locked_regfile u_dut (
        .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rsv(iss_rsv), .iss_rd(iss_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .locked_any(locked_any)
    );

    locked_regfile #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_ready(nb_iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rsv(iss_rsv), .iss_rd(iss_rd),
        .out_valid(nb_out_valid), .out_ready(out_ready),
        .out_rs1_data(nb_out_rs1_data), .out_rs2_data(nb_out_rs2_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .locked_any(nb_locked_any)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rsv = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
        out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h5555_5555;
        iss_valid = 1'b1; iss_rs1 = 5'd3; iss_rs2 = 5'd3; iss_rsv = 1'b1; iss_rd = 5'd3;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (locked_any !== 1'b0) begin failures++; $display("FAIL reset_locked_any: got %b want 0", locked_any); end
        reset = 1'b1;
        idle();
        iss_valid = 1'b1; iss_rs1 = 5'd3; iss_rs2 = 5'd3;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", iss_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL reset_read_valid: got %b want 1", out_valid); end
        checks++; if (out_rs1_data !== 32'h0) begin failures++; $display("FAIL reset_r3_zero: got %h want 0", out_rs1_data); end
        idle();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_read();
        do_reset();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0;
        iss_valid = 1'b1; iss_rs1 = 5'd5; iss_rs2 = 5'd0;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL read_ready: got %b want 1", iss_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL read_valid: got %b want 1", out_valid); end
        checks++; if (out_rs1_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_r5: got %h want deadbeef", out_rs1_data); end
        checks++; if (out_rs2_data !== 32'h0) begin failures++; $display("FAIL read_r0: got %h want 0", out_rs2_data); end
        // An unlocked source that is written in the same cycle returns the incoming data.
        iss_rs1 = 5'd5; iss_rs2 = 5'd5;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0011;
        tick();
        checks++; if (out_rs1_data !== 32'h11 || out_rs2_data !== 32'h11) begin
            failures++; $display("FAIL read_wb_fwd: got %h/%h want 11/11", out_rs1_data, out_rs2_data); end
        idle();
    endtask

    task automatic test_lock_bypass();
        do_reset();
        iss_valid = 1'b1; iss_rsv = 1'b1; iss_rd = 5'd7;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL lock_rsv_ready: got %b want 1", iss_ready); end
        tick();
        checks++; if (locked_any !== 1'b1) begin failures++; $display("FAIL lock_any_set: got %b want 1", locked_any); end
        iss_rsv = 1'b0; iss_rs1 = 5'd7; iss_rs2 = 5'd0;
        #1;
        checks++; if (iss_ready !== 1'b0 || nb_iss_ready !== 1'b0) begin
            failures++; $display("FAIL lock_blocked: got %b/%b want 0/0", iss_ready, nb_iss_ready); end
        tick();
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL lock_blocked2: got %b want 0", iss_ready); end
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL lock_bypass_ready: got %b want 1", iss_ready); end
        checks++; if (nb_iss_ready !== 1'b0) begin failures++; $display("FAIL lock_nobypass_ready: got %b want 0", nb_iss_ready); end
        tick();
        wb_en = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h1234) begin
            failures++; $display("FAIL lock_bypass_data: got v=%b %h want v=1 1234", out_valid, out_rs1_data); end
        checks++; if (locked_any !== 1'b0) begin failures++; $display("FAIL lock_any_clr: got %b want 0", locked_any); end
        #1;
        checks++; if (nb_iss_ready !== 1'b1) begin failures++; $display("FAIL lock_nobypass_late: got %b want 1", nb_iss_ready); end
        tick();
        checks++; if (nb_out_valid !== 1'b1 || nb_out_rs1_data !== 32'h1234) begin
            failures++; $display("FAIL lock_nobypass_data: got v=%b %h want v=1 1234", nb_out_valid, nb_out_rs1_data); end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        iss_valid = 1'b1; iss_rsv = 1'b1; iss_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_rsv%0d: got %b want 1", i, iss_ready); end
            tick();
        end
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_full: got %b want 0", iss_ready); end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hAA;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sat_rel_ready: got %b want 1", iss_ready); end
        tick();
        wb_en = 1'b0;
        #1;
        checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL sat_still3: got %b want 0", iss_ready); end
        iss_valid = 1'b0; iss_rsv = 1'b0;
        wb_en = 1'b1;
        tick(); tick();
        checks++; if (locked_any !== 1'b1) begin failures++; $display("FAIL sat_one_left: got %b want 1", locked_any); end
        tick();
        checks++; if (locked_any !== 1'b0) begin failures++; $display("FAIL sat_drained: got %b want 0", locked_any); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
        tick();
        wb_en = 1'b0;
        iss_valid = 1'b1; iss_rs1 = 5'd2; iss_rs2 = 5'd2; out_ready = 1'b0;
        tick();
        iss_rs2 = 5'd0;
        wb_en = 1'b1; wb_data = 32'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d: got %b want 0", i, iss_ready); end
            checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h22 || out_rs2_data !== 32'h22) begin
                failures++; $display("FAIL bp_hold%0d: got v=%b %h/%h want v=1 22/22", i, out_valid, out_rs1_data, out_rs2_data); end
            tick();
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got %b want 1", iss_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h99 || out_rs2_data !== 32'h0) begin
            failures++; $display("FAIL bp_next: got v=%b %h/%h want v=1 99/0", out_valid, out_rs1_data, out_rs2_data); end
        iss_rs1 = 5'd0; iss_rs2 = 5'd2;
        tick();
        checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h0 || out_rs2_data !== 32'h99) begin
            failures++; $display("FAIL bp_no_bubble: got v=%b %h/%h want v=1 0/99", out_valid, out_rs1_data, out_rs2_data); end
        iss_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b want 0", out_valid); end
        idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        iss_valid = 1'b1; iss_rsv = 1'b1; iss_rd = 5'd4;
        tick(); tick();
        iss_valid = 1'b0; iss_rsv = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (locked_any !== 1'b1 || out_valid !== 1'b1) begin
            failures++; $display("FAIL mid_pre: got any=%b v=%b want 1/1", locked_any, out_valid); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (out_valid !== 1'b0 || locked_any !== 1'b0) begin
            failures++; $display("FAIL mid_cleared: got v=%b any=%b want 0/0", out_valid, locked_any); end
        iss_valid = 1'b1; iss_rs1 = 5'd4; iss_rs2 = 5'd4;
        #1;
        checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL mid_issue: got %b want 1", iss_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h0) begin
            failures++; $display("FAIL mid_read: got v=%b %h want v=1 0", out_valid, out_rs1_data); end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        test_reset();
        test_read();
        test_lock_bypass();
        test_saturation();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
